rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
- 4-requester round-robin arbiter with grant hold and an optional hold timeout.
- Sits directly upstream of the 4-to-2 encoder.
- Drives a registered one-hot grant vector that the encoder converts to a 2-bit index.
- Also provides that index directly, plus a valid flag and a timeout pulse, so the encoder input is guaranteed one-hot or zero.

Parameters:
- MAX_HOLD, 16, max cycles a grant may be held before forced release; 0 disables the timeout.
- CNT_W, 8, width of the hold counter; MAX_HOLD must be below 2**CNT_W.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines; bit i is requester i; any combination is legal.
- release  input  1  the current grant holder finishes its transfer this cycle.
- grant  output  4  registered one-hot grant; 4'b0000 when nothing is granted.
- grant_valid  output  1  high while grant is non-zero.
- grant_idx  output  2  binary index of the granted requester; holds its last value when grant_valid=0.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (rst=1 at a clock edge) sets: grant=0, grant_valid=0, grant_idx=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE.
  - ptr is the internal 2-bit priority pointer; requester ptr has highest priority.
  - Reset overrides everything, including an active grant: grant drops at that edge with no timeout pulse.
- State IDLE:
  - Grant is zero. If req!=0 at a clock edge, pick the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - At that same edge, load grant=onehot(k), grant_idx=k, grant_valid=1, hold_cnt=0, and move to GRANT.
  - Latency: req sampled at edge N gives grant visible after edge N.
  - If req==0, stay in IDLE.
- State GRANT:
  - grant, grant_idx and grant_valid are held stable.
  - hold_cnt increments by 1 each cycle and saturates at its maximum value (no wrap-around).
  - Release conditions, checked at each edge in this priority:
    - (a) release=1;
    - (b) req[grant_idx]=0, i.e. the holder withdrew;
    - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1, i.e. the grant has been held MAX_HOLD cycles.
  - On any release condition, at that edge: grant=0, grant_valid=0, ptr=grant_idx+1 (mod 4, so 3 wraps to 0), and move to IDLE.
  - timeout=1 for exactly one cycle only when (c) alone caused the release. If (a) or (b) is true in the same cycle as (c), timeout stays 0.
- Bubble: after any release, grant_valid is low for at least one full cycle before the next grant. No back-to-back grants.
- Invariants:
  - grant has at most one bit set.
  - grant_valid == (grant!=0).
  - When grant_valid=1, grant == 1<<grant_idx.
- Boundary cases:
  - The holder re-requesting after release gets lowest priority on the next arbitration.
  - release=1 while in IDLE is ignored.
  - With all 4 requesting continuously, grants rotate 0,1,2,3,0,...
  - MAX_HOLD=1: the grant lasts one cycle and timeout pulses whenever release or withdraw is not also present.
- Implementation: 2-state FSM plus pointer, counter and output registers. All outputs registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then single request: rst 2 cycles; req=4'b0100, release=0 → one edge later grant=4'b0100, grant_idx=2, grant_valid=1; held; release=1 for one cycle → grant=0 next edge, ptr=3.
- Round-robin fairness: after reset, req=4'b1111 held; pulse release 1 cycle after each grant → grant sequence 0001, 0010, 0100, 1000, 0001, each separated by a 1-cycle grant_valid=0 bubble.
- Priority rotation: after reset, grant 0 is released; then req=4'b0101 → grant=4'b0100 (idx 2), not idx 0; after its release with req=4'b0101 still asserted → grant=4'b0001.
- Timeout: MAX_HOLD=4, req=4'b0010 held, release=0 → grant_valid high exactly 4 cycles, then timeout=1 for 1 cycle with grant=0; re-grant to idx 1 after the bubble.
- Simultaneous events: MAX_HOLD=4, release=1 in the 4th grant cycle → grant drops and timeout stays 0. Separately, the holder drops req mid-grant → grant drops at the next edge with timeout=0.
- Reset mid-operation: grant=4'b1000 active, rst=1 for 1 cycle → grant=0, grant_idx=0, timeout=0. Next req=4'b1001 → grant=4'b0001 (ptr back to 0).

Source files
------------

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant hold and optional hold timeout.
// The release input is named release_grant because `release` is a reserved word.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       release_grant,
  output logic [3:0] grant,
  output logic       grant_valid,
  output logic [1:0] grant_idx,
  output logic       timeout
);

  localparam bit               TimeoutEn = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HoldLast  = TimeoutEn ? CNT_W'(MAX_HOLD - 1) : '0;

  typedef enum logic {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]       grant_q, grant_d;
  logic             grant_valid_q, grant_valid_d;
  logic [1:0]       grant_idx_q, grant_idx_d;
  logic             timeout_q, timeout_d;

  logic [1:0] pick_idx;
  logic       pick_found;
  logic [1:0] scan_idx;
  logic       hold_expired;
  logic       holder_done;
  logic       rel_any;

  // Scan from ptr+3 down to ptr so the lowest offset from ptr wins.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    scan_idx   = '0;
    for (int i = 3; i >= 0; i--) begin
      scan_idx = ptr_q + 2'(i);
      if (req[scan_idx]) begin
        pick_idx   = scan_idx;
        pick_found = 1'b1;
      end
    end
  end

  assign hold_expired = TimeoutEn && (hold_cnt_q == HoldLast);
  assign holder_done  = release_grant || !req[grant_idx_q];
  assign rel_any      = holder_done || hold_expired;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_found) state_d = StGrant;
      StGrant: if (rel_any)    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    timeout_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d       = 4'b0001 << pick_idx;
          grant_idx_d   = pick_idx;
          grant_valid_d = 1'b1;
          hold_cnt_d    = '0;
        end
      end
      StGrant: begin
        if (rel_any) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          ptr_d         = grant_idx_q + 2'd1;
          // Only a pure expiry counts as a forced revoke.
          timeout_d     = hold_expired && !holder_done;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: one instance with MAX_HOLD=4, one with the timeout disabled.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       rel;
  logic [3:0] grant, grant0;
  logic       grant_valid, grant_valid0;
  logic [1:0] grant_idx, grant_idx0;
  logic       timeout, timeout0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .release_grant (rel),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_idx     (grant_idx),
    .timeout       (timeout)
  );

  rr_arbiter4 #(.MAX_HOLD(0), .CNT_W(8)) dut0 (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .release_grant (rel),
    .grant         (grant0),
    .grant_valid   (grant_valid0),
    .grant_idx     (grant_idx0),
    .timeout       (timeout0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic v,
                            input logic [1:0] idx, input logic to);
    check({tag, ".grant"}, grant, g);
    check({tag, ".valid"}, grant_valid, v);
    check({tag, ".idx"}, grant_idx, idx);
    check({tag, ".timeout"}, timeout, to);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    rel = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [3:0] rr_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    // Reset then single request.
    do_reset();
    expect_out("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    req = 4'b0100;
    tick();
    expect_out("single.grant", 4'b0100, 1'b1, 2'd2, 1'b0);
    tick();
    expect_out("single.hold", 4'b0100, 1'b1, 2'd2, 1'b0);
    rel = 1'b1;
    tick();
    expect_out("single.rel", 4'b0000, 1'b0, 2'd2, 1'b0);
    rel = 1'b0;
    req = 4'b1111;
    tick();
    check("single.ptr3", grant, 4'b1000);

    // Round-robin fairness.
    do_reset();
    req = 4'b1111;
    tick();
    check("rr.first", grant, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      rel = 1'b1;
      tick();
      check("rr.bubble", grant_valid, 1'b0);
      check("rr.bubble_grant", grant, 4'b0000);
      rel = 1'b0;
      tick();
      check("rr.next", grant, rr_seq[i]);
    end

    // Priority rotation.
    do_reset();
    req = 4'b0001;
    tick();
    check("rot.g0", grant, 4'b0001);
    rel = 1'b1;
    tick();
    check("rot.rel0", grant, 4'b0000);
    rel = 1'b0;
    req = 4'b0101;
    tick();
    expect_out("rot.g2", 4'b0100, 1'b1, 2'd2, 1'b0);
    rel = 1'b1;
    tick();
    check("rot.rel2", grant, 4'b0000);
    rel = 1'b0;
    tick();
    expect_out("rot.g0b", 4'b0001, 1'b1, 2'd0, 1'b0);

    // Timeout at MAX_HOLD=4; the disabled instance keeps holding.
    do_reset();
    req = 4'b0010;
    tick();
    expect_out("to.g", 4'b0010, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to.held", grant_valid, 1'b1);
      check("to.held_to", timeout, 1'b0);
    end
    tick();
    expect_out("to.fire", 4'b0000, 1'b0, 2'd1, 1'b1);
    check("to.nolimit.grant", grant0, 4'b0010);
    check("to.nolimit.timeout", timeout0, 1'b0);
    tick();
    expect_out("to.regrant", 4'b0010, 1'b1, 2'd1, 1'b0);
    check("to.nolimit.valid", grant_valid0, 1'b1);
    check("to.nolimit.idx", grant_idx0, 2'd1);

    // Release coinciding with expiry.
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    tick();
    tick();
    rel = 1'b1;
    tick();
    expect_out("sim.rel", 4'b0000, 1'b0, 2'd1, 1'b0);
    rel = 1'b0;

    // Withdraw coinciding with expiry.
    do_reset();
    req = 4'b1000;
    tick();
    tick();
    tick();
    tick();
    req = 4'b0000;
    tick();
    expect_out("sim.wd_exp", 4'b0000, 1'b0, 2'd3, 1'b0);

    // Withdraw mid-grant.
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    req = 4'b0000;
    tick();
    expect_out("sim.withdraw", 4'b0000, 1'b0, 2'd2, 1'b0);

    // Release while idle is ignored.
    do_reset();
    rel = 1'b1;
    tick();
    check("idle.rel", grant_valid, 1'b0);
    req = 4'b0001;
    tick();
    expect_out("idle.rel_grant", 4'b0001, 1'b1, 2'd0, 1'b0);
    tick();
    check("idle.rel_drop", grant, 4'b0000);
    rel = 1'b0;

    // Reset mid-operation.
    do_reset();
    req = 4'b1000;
    tick();
    check("rstmid.g3", grant, 4'b1000);
    rst = 1'b1;
    tick();
    expect_out("rstmid.rst", 4'b0000, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    req = 4'b1001;
    tick();
    expect_out("rstmid.ptr0", 4'b0001, 1'b1, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
